load_store_unit: RTL and testbench

- Initiator side of the 64-bit data-memory port, sitting in the MEM stage between the pipeline and the data memory.
- Converts RV64 load/store requests (B/H/W/D, signed/unsigned) into full 8-byte memory accesses.
- Narrow stores use a two-cycle read-modify-write; loads are sign- or zero-extended.
- Stalls the pipeline via req_ready and flags out-of-range or illegal requests.

---
 rtl/load_store_unit_if.sv | 32 +++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Pipeline request/response handshake and 64-bit data-memory bus.
// master = pipeline + memory side, slave = load_store_unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_error;
  logic [63:0] resp_rdata;
  logic [63:0] Memory_Address;
  logic [63:0] Write_Data;
  logic        MemWrite;
  logic        MemRead;
  logic [63:0] Read_Data;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_error, resp_rdata,
    input  Memory_Address, Write_Data, MemWrite, MemRead,
    output Read_Data
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_error, resp_rdata,
    output Memory_Address, Write_Data, MemWrite, MemRead,
    input  Read_Data
  );
endinterface

// File: rtl/load_store_unit.sv
// RV64 load/store unit: 8-byte accesses, RMW narrow stores, load extension.
// Optional: define LSU_MISALIGN_TRAP_EN to reject misaligned accesses.
module load_store_unit #(
  parameter int MEM_BYTES = 200
) (
  input logic clock,
  input logic reset,
  load_store_unit_if.slave bus
);

  typedef enum logic {
    IDLE,
    RMW_WRITE
  } state_t;

  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

  state_t      state;
  logic [63:0] rmw_addr;
  logic [63:0] rmw_data;

  logic accept;
  logic f3_ok;
  logic range_ok;
  logic align_ok;
  logic legal;
  logic do_load;
  logic do_sd;
  logic do_rmw;
  logic is_dword;

  function automatic logic [63:0] extend(
    input logic [2:0]  f3,
    input logic [63:0] d
  );
    logic [63:0] r;
    unique case (f3)
      3'd0:    r = {{56{d[7]}}, d[7:0]};
      3'd1:    r = {{48{d[15]}}, d[15:0]};
      3'd2:    r = {{32{d[31]}}, d[31:0]};
      3'd4:    r = {56'd0, d[7:0]};
      3'd5:    r = {48'd0, d[15:0]};
      3'd6:    r = {32'd0, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] merge(
    input logic [1:0]  sz,
    input logic [63:0] old,
    input logic [63:0] w
  );
    logic [63:0] r;
    unique case (sz)
      2'd0:    r = {old[63:8], w[7:0]};
      2'd1:    r = {old[63:16], w[15:0]};
      2'd2:    r = {old[63:32], w[31:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  assign bus.req_ready = (state == IDLE) && !reset;
  assign accept = bus.req_valid && bus.req_ready;
  assign is_dword = (bus.req_funct3[1:0] == 2'd3);

  // Request legality: funct3 code, address range, optional alignment
  always_comb begin
    f3_ok = 1'b0;
    if (bus.req_write) f3_ok = !bus.req_funct3[2];
    else               f3_ok = (bus.req_funct3 != 3'd7);
    range_ok = (bus.req_addr <= ADDR_MAX);
`ifdef LSU_MISALIGN_TRAP_EN
    unique case (bus.req_funct3[1:0])
      2'd0:    align_ok = 1'b1;
      2'd1:    align_ok = (bus.req_addr[0] == 1'b0);
      2'd2:    align_ok = (bus.req_addr[1:0] == 2'd0);
      default: align_ok = (bus.req_addr[2:0] == 3'd0);
    endcase
`else
    align_ok = 1'b1;
`endif
    legal   = f3_ok && range_ok && align_ok;
    do_load = accept && legal && !bus.req_write;
    do_sd   = accept && legal && bus.req_write && is_dword;
    do_rmw  = accept && legal && bus.req_write && !is_dword;
  end

  // Memory bus drive; all strobes and buses idle at zero during reset
  always_comb begin
    bus.MemRead        = 1'b0;
    bus.MemWrite       = 1'b0;
    bus.Memory_Address = '0;
    bus.Write_Data     = '0;
    unique case (1'b1)
      (state == RMW_WRITE) && !reset: begin
        bus.MemWrite       = 1'b1;
        bus.Memory_Address = rmw_addr;
        bus.Write_Data     = rmw_data;
      end
      do_load || do_rmw: begin
        bus.MemRead        = 1'b1;
        bus.Memory_Address = bus.req_addr;
      end
      do_sd: begin
        bus.MemWrite       = 1'b1;
        bus.Memory_Address = bus.req_addr;
        bus.Write_Data     = bus.req_wdata;
      end
      default: begin
        bus.MemRead = 1'b0;
      end
    endcase
  end

  // Control FSM with registered response and RMW capture
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      bus.resp_valid <= 1'b0;
      bus.resp_error <= 1'b0;
      bus.resp_rdata <= '0;
      rmw_addr       <= '0;
      rmw_data       <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.resp_error <= 1'b0;
      bus.resp_rdata <= '0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (!legal) begin
              bus.resp_valid <= 1'b1;
              bus.resp_error <= 1'b1;
            end else if (!bus.req_write) begin
              bus.resp_valid <= 1'b1;
              bus.resp_rdata <= extend(bus.req_funct3, bus.Read_Data);
            end else if (is_dword) begin
              bus.resp_valid <= 1'b1;
            end else begin
              rmw_addr <= bus.req_addr;
              rmw_data <= merge(bus.req_funct3[1:0], bus.Read_Data,
                                bus.req_wdata);
              state    <= RMW_WRITE;
            end
          end
        end
        RMW_WRITE: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 200-byte memory.
// Expected values are hand-computed per step.
module tb_load_store_unit;

  localparam int MB = 200;

  logic clock;
  logic reset;
  logic mem_clear;
  logic [7:0] mem [0:MB-1];
  int mem_writes;

  int n_checks;
  int n_errors;

  int rd_c, wr_c, lat, stall;
  logic err;
  logic [63:0] rdata;
  int wr_before;

  load_store_unit_if bus();

  load_store_unit #(.MEM_BYTES(MB)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    bus.Read_Data = '0;
    if (bus.MemRead && bus.Memory_Address <= 64'(MB - 8))
      for (int i = 0; i < 8; i++)
        bus.Read_Data[8*i +: 8] = mem[int'(bus.Memory_Address[7:0]) + i];
  end

  always @(posedge clock) begin
    if (mem_clear) begin
      for (int i = 0; i < MB; i++)
        mem[i] <= (i >= MB - 8) ? 8'(i) : 8'h00;
    end else if (bus.MemWrite && bus.Memory_Address <= 64'(MB - 8)) begin
      for (int i = 0; i < 8; i++)
        mem[int'(bus.Memory_Address[7:0]) + i] <= bus.Write_Data[8*i +: 8];
    end
  end

  always @(posedge clock)
    if (bus.MemWrite) mem_writes <= mem_writes + 1;

  function automatic logic [63:0] get64(input int a);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = mem[a + i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic w, input logic [2:0] f3,
                     input logic [63:0] a, input logic [63:0] d);
    rd_c = 0; wr_c = 0; lat = 0; stall = 0;
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_funct3 = f3;
    bus.req_addr = a;
    bus.req_wdata = d;
    #1;
    if (!bus.req_ready) stall++;
    if (bus.MemRead) rd_c++;
    if (bus.MemWrite) wr_c++;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    lat = 1;
    while (!bus.resp_valid && lat < 5) begin
      if (!bus.req_ready) stall++;
      if (bus.MemRead) rd_c++;
      if (bus.MemWrite) wr_c++;
      @(posedge clock); #1;
      lat++;
    end
    err = bus.resp_error;
    rdata = bus.resp_rdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    mem_writes = 0;
    reset = 1'b1;
    mem_clear = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_error", 64'(bus.resp_error), 64'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_strobes", 64'({bus.MemRead, bus.MemWrite}), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    mem_clear = 1'b0;
    #1;
    chk("idle_ready", 64'(bus.req_ready), 64'd1);
    chk("idle_addr", bus.Memory_Address, 64'd0);

    txn(1'b1, 3'd3, 64'd16, 64'h1122334455667788);
    chk("sd_wr_cycles", 64'(wr_c), 64'd1);
    chk("sd_latency", 64'(lat), 64'd1);
    chk("sd_stall", 64'(stall), 64'd0);
    chk("sd_mem", get64(16), 64'h1122334455667788);
    chk("sd_byte16", 64'(mem[16]), 64'h88);
    chk("sd_byte23", 64'(mem[23]), 64'h11);

    txn(1'b0, 3'd3, 64'd16, 64'd0);
    chk("ld16_data", rdata, 64'h1122334455667788);
    chk("ld16_latency", 64'(lat), 64'd1);
    chk("ld16_err", 64'(err), 64'd0);

    txn(1'b1, 3'd0, 64'd17, 64'h00000000000000AB);
    chk("sb_stall", 64'(stall), 64'd1);
    chk("sb_latency", 64'(lat), 64'd2);
    chk("sb_rd_wr", 64'({rd_c[3:0], wr_c[3:0]}), 64'h11);
    txn(1'b0, 3'd3, 64'd16, 64'd0);
    chk("sb_ld16", rdata, 64'h112233445566AB88);
    chk("sb_byte24", 64'(mem[24]), 64'h00);

    txn(1'b1, 3'd2, 64'd0, 64'h0000000080000000);
    chk("sw_latency", 64'(lat), 64'd2);
    txn(1'b0, 3'd2, 64'd0, 64'd0);
    chk("lw0", rdata, 64'hFFFFFFFF80000000);
    txn(1'b0, 3'd6, 64'd0, 64'd0);
    chk("lwu0", rdata, 64'h0000000080000000);
    txn(1'b0, 3'd0, 64'd3, 64'd0);
    chk("lb3", rdata, 64'hFFFFFFFFFFFFFF80);
    txn(1'b0, 3'd4, 64'd3, 64'd0);
    chk("lbu3", rdata, 64'h0000000000000080);

    wr_before = mem_writes;
    txn(1'b0, 3'd3, 64'd193, 64'd0);
    chk("ld193_err", 64'(err), 64'd1);
    chk("ld193_strobes", 64'(rd_c + wr_c), 64'd0);
    chk("ld193_rdata", rdata, 64'd0);
    txn(1'b1, 3'd3, 64'hFFFFFFFFFFFFFFF8, 64'hDEADBEEFDEADBEEF);
    chk("sdhi_err", 64'(err), 64'd1);
    chk("sdhi_strobes", 64'(rd_c + wr_c), 64'd0);
    chk("range_no_write", 64'(mem_writes - wr_before), 64'd0);
    txn(1'b0, 3'd3, 64'd192, 64'd0);
    chk("ld192_err", 64'(err), 64'd0);
    chk("ld192_data", rdata, 64'hC7C6C5C4C3C2C1C0);

    txn(1'b0, 3'd7, 64'd8, 64'd0);
    chk("ldf7_err", 64'(err), 64'd1);
    chk("ldf7_strobes", 64'(rd_c + wr_c), 64'd0);
    txn(1'b1, 3'd4, 64'd8, 64'hFF);
    chk("stf4_err", 64'(err), 64'd1);
    chk("stf4_mem", get64(8), 64'd0);

    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_funct3 = 3'd1;
    bus.req_addr = 64'd40;
    bus.req_wdata = 64'hBEEF;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    chk("sh_in_rmw", 64'({bus.MemWrite, bus.req_ready}), 64'b10);
    reset = 1'b1;
    #1;
    chk("rst_rmw_strobes", 64'({bus.MemRead, bus.MemWrite}), 64'd0);
    chk("rst_rmw_addr", bus.Memory_Address, 64'd0);
    @(posedge clock); #1;
    chk("rst_rmw_mem", get64(40), 64'd0);
    chk("rst_rmw_resp", 64'({bus.resp_valid, bus.resp_error}), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_rmw_idle", 64'({bus.req_ready, bus.MemWrite}), 64'b10);
    txn(1'b0, 3'd3, 64'd40, 64'd0);
    chk("ld40_after_abort", rdata, 64'd0);

    txn(1'b1, 3'd0, 64'd4, 64'hFF);
    txn(1'b0, 3'd1, 64'd3, 64'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lh3_err", 64'(err), 64'd1);
    chk("lh3_strobes", 64'(rd_c + wr_c), 64'd0);
`else
    chk("lh3_err", 64'(err), 64'd0);
    chk("lh3_data", rdata, 64'hFFFFFFFFFFFFFF80);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
